// File: rtl/board_store.sv
// rtl/board_store.sv - 4x4 tile board with renderer lookup and CLEAR/WRITE/SPAWN/NOP command engine
// Optional macro BOARD_SHADOW_EN: renderer reads a per-frame shadow copy latched on VGA_vs falling edge.
module board_store #(
    parameter logic [3:0]  MAX_TYPE  = 4'd10,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk_VGA,
    input  logic       rst,
    input  logic [3:0] BlockID,
    output logic [3:0] BlockType,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_addr,
    input  logic [3:0] cmd_data,
    output logic       rsp_valid,
    output logic       rsp_ok,
    output logic [3:0] rsp_addr,
    output logic [4:0] empty_cnt,
    output logic [3:0] max_type,
    input  logic       VGA_vs
);

    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SPAWN = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t      state, state_nx;
    logic [3:0]  board [16];
    logic [15:0] lfsr;
    logic [3:0]  idx, idx_nx, val, val_nx, probes, probes_nx;
    logic        wr_en, clr;
    logic [3:0]  wr_addr, wr_data;
    logic        rsp_valid_nx, rsp_ok_nx;
    logic [3:0]  rsp_addr_nx;

    assign cmd_ready = (state == IDLE);

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        val_nx       = val;
        probes_nx    = probes;
        wr_en        = 1'b0;
        clr          = 1'b0;
        wr_addr      = 4'd0;
        wr_data      = 4'd0;
        rsp_valid_nx = 1'b0;
        rsp_ok_nx    = 1'b0;
        rsp_addr_nx  = 4'd0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_CLEAR: begin
                            clr          = 1'b1;
                            rsp_valid_nx = 1'b1;
                            rsp_ok_nx    = 1'b1;
                        end
                        OP_WRITE: begin
                            rsp_valid_nx = 1'b1;
                            rsp_addr_nx  = cmd_addr;
                            if (cmd_data <= MAX_TYPE) begin
                                wr_en     = 1'b1;
                                wr_addr   = cmd_addr;
                                wr_data   = cmd_data;
                                rsp_ok_nx = 1'b1;
                            end
                        end
                        OP_SPAWN: begin
                            idx_nx    = lfsr[3:0];
                            val_nx    = (lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
                            probes_nx = 4'd0;
                            state_nx  = SCAN;
                        end
                        OP_NOP: begin
                            rsp_valid_nx = 1'b1;
                            rsp_ok_nx    = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            SCAN: begin
                if (board[idx] == 4'd0) begin
                    wr_en        = 1'b1;
                    wr_addr      = idx;
                    wr_data      = val;
                    rsp_valid_nx = 1'b1;
                    rsp_ok_nx    = 1'b1;
                    rsp_addr_nx  = idx;
                    state_nx     = IDLE;
                end else if (probes == 4'd15) begin
                    // Sixteenth occupied probe: the board is full.
                    rsp_valid_nx = 1'b1;
                    state_nx     = IDLE;
                end else begin
                    idx_nx    = idx + 4'd1;
                    probes_nx = probes + 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_VGA or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= SEED;
            idx       <= 4'd0;
            val       <= 4'd0;
            probes    <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_ok    <= 1'b0;
            rsp_addr  <= 4'd0;
            for (int i = 0; i < 16; i++) board[i] <= 4'd0;
        end else begin
            state     <= state_nx;
            lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            idx       <= idx_nx;
            val       <= val_nx;
            probes    <= probes_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_ok    <= rsp_ok_nx;
            rsp_addr  <= rsp_addr_nx;
            if (clr) begin
                for (int i = 0; i < 16; i++) board[i] <= 4'd0;
            end else if (wr_en) begin
                board[wr_addr] <= wr_data;
            end
        end
    end

    always_comb begin
        empty_cnt = 5'd0;
        max_type  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (board[i] == 4'd0) empty_cnt = empty_cnt + 5'd1;
            if (board[i] > max_type) max_type = board[i];
        end
    end

`ifdef BOARD_SHADOW_EN
    logic [3:0] shadow [16];
    logic       vs_q1, vs_q2;

    // Copy fires one cycle after the registered vsync falling edge; a board write
    // on the same edge lands in the next frame's copy.
    always_ff @(posedge clk_VGA or posedge rst) begin
        if (rst) begin
            vs_q1 <= 1'b1;
            vs_q2 <= 1'b1;
            for (int i = 0; i < 16; i++) shadow[i] <= 4'd0;
        end else begin
            vs_q1 <= VGA_vs;
            vs_q2 <= vs_q1;
            if (vs_q2 && !vs_q1) begin
                for (int i = 0; i < 16; i++) shadow[i] <= board[i];
            end
        end
    end

    assign BlockType = shadow[BlockID];
`else
    logic unused_vs;
    assign unused_vs = VGA_vs;
    assign BlockType = board[BlockID];
`endif

endmodule

// File: tb/tb_board_store.sv
// tb/tb_board_store.sv - directed self-checking bench for board_store
module tb_board_store;

    logic       clk_VGA = 1'b0;
    logic       rst;
    logic [3:0] BlockID;
    logic [3:0] BlockType;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_addr;
    logic [3:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ok;
    logic [3:0] rsp_addr;
    logic [4:0] empty_cnt;
    logic [3:0] max_type;
    logic       VGA_vs;

    int errors = 0;
    int checks = 0;

    board_store dut (
        .clk_VGA  (clk_VGA),
        .rst      (rst),
        .BlockID  (BlockID),
        .BlockType(BlockType),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ok   (rsp_ok),
        .rsp_addr (rsp_addr),
        .empty_cnt(empty_cnt),
        .max_type (max_type),
        .VGA_vs   (VGA_vs)
    );

    always #5 clk_VGA = ~clk_VGA;

    // Drives one command from IDLE; returns at the negedge after the accept edge.
    task automatic send(input logic [1:0] op, input logic [3:0] addr, input logic [3:0] data);
        @(negedge clk_VGA);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        @(posedge clk_VGA);
        @(negedge clk_VGA);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'b11; cmd_addr = 4'd0; cmd_data = 4'd0;
        BlockID = 4'd0; VGA_vs = 1'b1;
        repeat (3) @(negedge clk_VGA);
        rst = 1'b0;
        @(negedge clk_VGA);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
        checks++; if (empty_cnt !== 5'd16) begin errors++; $display("FAIL reset_empty got=%0d exp=16", empty_cnt); end
        checks++; if (max_type !== 4'd0) begin errors++; $display("FAIL reset_max got=%0d exp=0", max_type); end
        for (int i = 0; i < 16; i++) begin
            BlockID = 4'(i);
            #1;
            checks++; if (BlockType !== 4'd0) begin errors++; $display("FAIL reset_blocktype id=%0d got=%0d exp=0", i, BlockType); end
        end
    endtask

    task automatic test_write;
        send(2'b01, 4'd5, 4'd3);
        checks++; if (rsp_valid !== 1'b1 || rsp_ok !== 1'b1 || rsp_addr !== 4'd5) begin
            errors++; $display("FAIL write_rsp got=v%0b ok%0b a%0d exp=v1 ok1 a5", rsp_valid, rsp_ok, rsp_addr); end
        checks++; if (empty_cnt !== 5'd15) begin errors++; $display("FAIL write_empty got=%0d exp=15", empty_cnt); end
        checks++; if (max_type !== 4'd3) begin errors++; $display("FAIL write_max got=%0d exp=3", max_type); end
`ifndef BOARD_SHADOW_EN
        BlockID = 4'd5; #1;
        checks++; if (BlockType !== 4'd3) begin errors++; $display("FAIL write_blocktype got=%0d exp=3", BlockType); end
`endif
        @(negedge clk_VGA);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL write_pulse_width got=%0b exp=0", rsp_valid); end
    endtask

    task automatic test_write_range;
        send(2'b01, 4'd2, 4'd11);
        checks++; if (rsp_valid !== 1'b1 || rsp_ok !== 1'b0 || rsp_addr !== 4'd2) begin
            errors++; $display("FAIL bad_write_rsp got=v%0b ok%0b a%0d exp=v1 ok0 a2", rsp_valid, rsp_ok, rsp_addr); end
        checks++; if (empty_cnt !== 5'd15) begin errors++; $display("FAIL bad_write_empty got=%0d exp=15", empty_cnt); end
`ifndef BOARD_SHADOW_EN
        BlockID = 4'd2; #1;
        checks++; if (BlockType !== 4'd0) begin errors++; $display("FAIL bad_write_cell got=%0d exp=0", BlockType); end
`endif
        send(2'b01, 4'd15, 4'd10);
        checks++; if (rsp_ok !== 1'b1 || rsp_addr !== 4'd15) begin
            errors++; $display("FAIL max_write_rsp got=ok%0b a%0d exp=ok1 a15", rsp_ok, rsp_addr); end
        checks++; if (max_type !== 4'd10 || empty_cnt !== 5'd14) begin
            errors++; $display("FAIL max_write_state got=max%0d empty%0d exp=max10 empty14", max_type, empty_cnt); end
    endtask

    task automatic test_spawn;
        int k;
        for (int i = 0; i < 16; i++)
            if (i != 9) send(2'b01, 4'(i), (i == 15) ? 4'd10 : 4'd1);
        checks++; if (empty_cnt !== 5'd1) begin errors++; $display("FAIL fill_empty got=%0d exp=1", empty_cnt); end
        send(2'b10, 4'd0, 4'd0);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL spawn_busy got=%0b exp=0", cmd_ready); end
        k = 0;
        for (int c = 1; c <= 20 && k == 0; c++) begin
            @(posedge clk_VGA); @(negedge clk_VGA);
            if (rsp_valid) k = c;
        end
        checks++; if (k < 1 || k > 16) begin errors++; $display("FAIL spawn_latency got=%0d exp=1..16", k); end
        checks++; if (rsp_ok !== 1'b1 || rsp_addr !== 4'd9) begin
            errors++; $display("FAIL spawn_rsp got=ok%0b a%0d exp=ok1 a9", rsp_ok, rsp_addr); end
        checks++; if (empty_cnt !== 5'd0) begin errors++; $display("FAIL spawn_empty got=%0d exp=0", empty_cnt); end
`ifndef BOARD_SHADOW_EN
        BlockID = 4'd9; #1;
        checks++; if (BlockType !== 4'd1 && BlockType !== 4'd2) begin
            errors++; $display("FAIL spawn_value got=%0d exp=1or2", BlockType); end
`endif
    endtask

    task automatic test_full_spawn;
        int k;
        int pulses;
        send(2'b10, 4'd0, 4'd0);
        k = 0;
        for (int c = 1; c <= 20 && k == 0; c++) begin
            @(posedge clk_VGA); @(negedge clk_VGA);
            if (rsp_valid) k = c;
        end
        checks++; if (k != 16) begin errors++; $display("FAIL full_latency got=%0d exp=16", k); end
        checks++; if (rsp_ok !== 1'b0 || rsp_addr !== 4'd0) begin
            errors++; $display("FAIL full_rsp got=ok%0b a%0d exp=ok0 a0", rsp_ok, rsp_addr); end
        checks++; if (empty_cnt !== 5'd0 || max_type !== 4'd10) begin
            errors++; $display("FAIL full_unchanged got=empty%0d max%0d exp=empty0 max10", empty_cnt, max_type); end
        send(2'b10, 4'd0, 4'd0);
        @(negedge clk_VGA);
        @(negedge clk_VGA);
        rst = 1'b1;
        @(negedge clk_VGA);
        checks++; if (empty_cnt !== 5'd16) begin errors++; $display("FAIL midscan_clear got=%0d exp=16", empty_cnt); end
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_VGA); @(negedge clk_VGA);
            if (rsp_valid) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL midscan_pulse got=%0d exp=0", pulses); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midscan_ready got=%0b exp=1", cmd_ready); end
    endtask

    task automatic test_busy_hold;
        int pulses;
        @(negedge clk_VGA);
        cmd_valid = 1'b1; cmd_op = 2'b10;
        @(posedge clk_VGA); @(negedge clk_VGA);
        cmd_op = 2'b11;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk_VGA); @(negedge clk_VGA);
            if (rsp_valid) begin
                pulses++;
                if (pulses == 2) cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        checks++; if (pulses != 2) begin errors++; $display("FAIL busy_hold_pulses got=%0d exp=2", pulses); end
        checks++; if (empty_cnt !== 5'd15) begin errors++; $display("FAIL busy_hold_empty got=%0d exp=15", empty_cnt); end
    endtask

    task automatic test_back_to_back;
        send(2'b00, 4'd0, 4'd0);
        checks++; if (rsp_valid !== 1'b1 || rsp_ok !== 1'b1 || rsp_addr !== 4'd0 || empty_cnt !== 5'd16 || max_type !== 4'd0) begin
            errors++; $display("FAIL clear got=v%0b ok%0b a%0d e%0d m%0d exp=v1 ok1 a0 e16 m0", rsp_valid, rsp_ok, rsp_addr, empty_cnt, max_type); end
        @(negedge clk_VGA);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 4'd3; cmd_data = 4'd5;
        @(posedge clk_VGA); @(negedge clk_VGA);
        checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 4'd3 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_first got=v%0b a%0d r%0b exp=v1 a3 r1", rsp_valid, rsp_addr, cmd_ready); end
        cmd_addr = 4'd4; cmd_data = 4'd6;
        @(posedge clk_VGA); @(negedge clk_VGA);
        cmd_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_ok !== 1'b1 || rsp_addr !== 4'd4) begin
            errors++; $display("FAIL b2b_second got=v%0b ok%0b a%0d exp=v1 ok1 a4", rsp_valid, rsp_ok, rsp_addr); end
        checks++; if (empty_cnt !== 5'd14 || max_type !== 4'd6) begin
            errors++; $display("FAIL b2b_board got=e%0d m%0d exp=e14 m6", empty_cnt, max_type); end
        @(posedge clk_VGA); @(negedge clk_VGA);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%0b exp=0", rsp_valid); end
    endtask

`ifdef BOARD_SHADOW_EN
    task automatic test_shadow;
        send(2'b00, 4'd0, 4'd0);
        send(2'b01, 4'd0, 4'd4);
        BlockID = 4'd0;
        @(negedge clk_VGA);
        checks++; if (BlockType !== 4'd0) begin errors++; $display("FAIL shadow_hold got=%0d exp=0", BlockType); end
        VGA_vs = 1'b0;
        @(posedge clk_VGA); @(negedge clk_VGA);
        checks++; if (BlockType !== 4'd0) begin errors++; $display("FAIL shadow_early got=%0d exp=0", BlockType); end
        @(posedge clk_VGA); @(negedge clk_VGA);
        checks++; if (BlockType !== 4'd4) begin errors++; $display("FAIL shadow_copy got=%0d exp=4", BlockType); end
        VGA_vs = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_write_range();
        test_spawn();
        test_full_spawn();
        test_busy_hold();
        test_back_to_back();
`ifdef BOARD_SHADOW_EN
        test_shadow();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
